// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin sequencer sharing one ALU between two requesters, one op in flight.
// Latency : request accepted at edge k, ALU settles in cycle k+1, rsp_valid high from cycle k+2.
// Backpr. : rsp_ready low holds the response and ALU inputs; both req*_ready stay low until it drains.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/ready/op/a/b         requester N (N = 0,1) valid/ready operation channel
//   alu_ctl, alu_a, alu_b           registered ALU control and operands
//   alu_out, alu_zero               combinational ALU result and zero flag
//   rsp_valid/ready/data/zero/id/err one-deep response register
// Optional: define ALU_ARB_ILLEGAL_OP_EN to flag illegal op codes on rsp_err.

module alu_share_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_ctl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_id,
   output logic             rsp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state;
   logic   last_grant;
   logic   id_q;
   logic   grant;
   logic   accept;

   // On a tie the port that did not win last time goes; otherwise the lone valid port wins.
   assign grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   // rst_n is folded in so both readies are low for the whole reset assertion.
   assign accept = (state == IDLE) && rst_n && (req0_valid || req1_valid);

   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;

`ifdef ALU_ARB_ILLEGAL_OP_EN
   logic err_q;
   logic sel_illegal;

   always_comb begin
      sel_illegal = 1'b1;
      case (grant ? req1_op : req0_op)
         4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: sel_illegal = 1'b0;
         default:                             sel_illegal = 1'b1;
      endcase
   end
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         alu_ctl    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
         rsp_id     <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
         err_q      <= 1'b0;
         rsp_err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_ctl    <= grant ? req1_op : req0_op;
                  alu_a      <= grant ? req1_a  : req0_a;
                  alu_b      <= grant ? req1_b  : req0_b;
                  id_q       <= grant;
                  last_grant <= grant;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                  err_q      <= sel_illegal;
`endif
                  state      <= EXEC;
               end
            end
            EXEC: begin
               // ALU inputs have been stable for a full cycle; capture its result.
`ifdef ALU_ARB_ILLEGAL_OP_EN
               rsp_data  <= err_q ? '0 : alu_out;
               rsp_zero  <= err_q | alu_zero;
               rsp_err   <= err_q;
`else
               rsp_data  <= alu_out;
               rsp_zero  <= alu_zero;
`endif
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level model of grant order and timing.
module tb_alu_share_arbiter;

   localparam int W = 64;
   localparam logic [W-1:0] ONES = '1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]   req0_op, req1_op, alu_ctl;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [W-1:0] alu_a, alu_b, alu_out, rsp_data;
   logic         alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_id, rsp_err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_id(rsp_id), .rsp_err(rsp_err)
   );

   // Behavioural ALU: illegal codes return 0.
   function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         4'd0:    r = a & b;
         4'd1:    r = a | b;
         4'd2:    r = a + b;
         4'd6:    r = a - b;
         4'd7:    r = ($signed(a) < $signed(b)) ? W'(1) : '0;
         4'd12:   r = ~(a | b);
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic bit is_legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
   endfunction

   assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
   assign alu_zero = (alu_out == '0);

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Transaction-level model: at most one op in flight from acceptance until its response retires.
   bit           m_busy = 1'b0;
   bit           m_last = 1'b1;
   bit           m_id;
   int           m_acc;
   logic [3:0]   m_op;
   logic [W-1:0] m_a, m_b;
   int           cyc = 0;
   int           n_hs = 0;
   bit           hold_valid = 1'b0;

   logic [W-1:0] obs_data;
   logic         obs_zero, obs_id, obs_err;
   int           obs_cyc;
   bit           q_id[$];
   logic [W-1:0] q_data[$];
   logic         q_zero[$];

   task automatic drive(input int p, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      if (p == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model, step past the rising edge.
   task automatic step();
      bit e_r0, e_r1, e_rv;
      logic [W-1:0] e_dat;
      @(negedge clk);
      e_r0 = rst_n && !m_busy && req0_valid && (!req1_valid || m_last);
      e_r1 = rst_n && !m_busy && req1_valid && (!req0_valid || !m_last);
      e_rv = m_busy && (cyc >= m_acc + 2);
      check("req0_ready", 64'(req0_ready), 64'(e_r0));
      check("req1_ready", 64'(req1_ready), 64'(e_r1));
      check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      if (m_busy) begin
         check("alu_ctl", 64'(alu_ctl), 64'(m_op));
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
      end
      if (e_rv) begin
         e_dat = alu_fn(m_op, m_a, m_b);
         check("rsp_data", rsp_data, e_dat);
         check("rsp_zero", 64'(rsp_zero), 64'(e_dat == '0));
         check("rsp_id", 64'(rsp_id), 64'(m_id));
         check("rsp_err", 64'(rsp_err), 64'(ERR_EN && !is_legal(m_op)));
      end
      if (rsp_valid && rsp_ready) begin
         obs_data = rsp_data; obs_zero = rsp_zero; obs_id = rsp_id; obs_err = rsp_err;
         obs_cyc = cyc;
         n_hs++;
         q_id.push_back(rsp_id); q_data.push_back(rsp_data); q_zero.push_back(rsp_zero);
      end
      if (e_rv && rsp_ready) m_busy = 1'b0;
      if (e_r0 || e_r1) begin
         m_busy = 1'b1;
         m_acc  = cyc;
         m_id   = e_r1;
         m_last = e_r1;
         m_op   = e_r1 ? req1_op : req0_op;
         m_a    = e_r1 ? req1_a  : req0_a;
         m_b    = e_r1 ? req1_b  : req0_b;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (e_r0 && !hold_valid) req0_valid = 1'b0;
      if (e_r1 && !hold_valid) req1_valid = 1'b0;
   endtask

   task automatic run_until_hs(input int bound);
      int start;
      start = n_hs;
      for (int i = 0; i < bound && n_hs == start; i++) step();
      check("hs_count", 64'(n_hs - start), 64'(1));
   endtask

   task automatic chk_reset_vals(input string p);
      check({p, "_req0_ready"}, 64'(req0_ready), 64'(0));
      check({p, "_req1_ready"}, 64'(req1_ready), 64'(0));
      check({p, "_alu_ctl"}, 64'(alu_ctl), 64'(0));
      check({p, "_alu_a"}, alu_a, '0);
      check({p, "_alu_b"}, alu_b, '0);
      check({p, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      check({p, "_rsp_data"}, rsp_data, '0);
      check({p, "_rsp_zero"}, 64'(rsp_zero), 64'(0));
      check({p, "_rsp_id"}, 64'(rsp_id), 64'(0));
      check({p, "_rsp_err"}, 64'(rsp_err), 64'(0));
   endtask

   function automatic logic [3:0] rand_op();
      logic [3:0] r;
      case ($urandom_range(0, 6))
         0: r = 4'd0;
         1: r = 4'd1;
         2: r = 4'd2;
         3: r = 4'd6;
         4: r = 4'd7;
         5: r = 4'd12;
         default: r = 4'($urandom);
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] rand_opnd();
      logic [W-1:0] r;
      case ($urandom_range(0, 5))
         0: r = '0;
         1: r = ONES;
         2: r = W'($urandom_range(0, 15));
         default: r = {$urandom, $urandom};
      endcase
      return r;
   endfunction

   initial begin
      int base;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = 4'd2; req1_op = 4'd2;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b0;

      // Reset state, with both requesters asserting valid.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst");
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single ADD from port 0.
      cyc = 0;
      rsp_ready = 1'b1;
      drive(0, 4'd2, W'(5), W'(7));
      run_until_hs(10);
      check("add_data", obs_data, W'(12));
      check("add_zero", 64'(obs_zero), 64'(0));
      check("add_id", 64'(obs_id), 64'(0));
      check("add_rsp_cycle", 64'(obs_cyc), 64'(2));

      // Reset during EXEC: in-flight NOR is discarded, arbitration history restarts.
      step();
      drive(1, 4'd12, '0, '0);
      step();
      drive(0, 4'd6, W'(9), W'(9));
      drive(1, 4'd7, W'(3), W'(4));
      #1 rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      m_busy = 1'b0;
      m_last = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Contention: both ports valid continuously, grants alternate starting with port 0.
      q_id.delete(); q_data.delete(); q_zero.delete();
      hold_valid = 1'b1;
      repeat (13) step();
      hold_valid = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("cont_count", 64'(q_id.size()), 64'(4));
      for (int i = 0; i < 4 && i < q_id.size(); i++)
         check("cont_id", 64'(q_id[i]), 64'(i % 2));
      if (q_id.size() >= 2) begin
         check("cont_sub_data", q_data[0], '0);
         check("cont_sub_zero", 64'(q_zero[0]), 64'(1));
         check("cont_slt_data", q_data[1], W'(1));
      end
      run_until_hs(10);

      // Backpressure: ten stalled response cycles, then exactly one handshake.
      rsp_ready = 1'b0;
      drive(0, 4'd2, rand_opnd(), rand_opnd());
      drive(1, 4'd6, rand_opnd(), rand_opnd());
      base = n_hs;
      repeat (12) step();
      check("bp_no_hs", 64'(n_hs - base), 64'(0));
      rsp_ready = 1'b1;
      step();
      check("bp_one_hs", 64'(n_hs - base), 64'(1));
      run_until_hs(10);

      // NOR / AND corners and an illegal op.
      drive(1, 4'd12, '0, '0);
      run_until_hs(10);
      check("nor_data", obs_data, ONES);
      check("nor_zero", 64'(obs_zero), 64'(0));
      check("nor_id", 64'(obs_id), 64'(1));
      drive(0, 4'd0, ONES, '0);
      run_until_hs(10);
      check("and_data", obs_data, '0);
      check("and_zero", 64'(obs_zero), 64'(1));
      drive(0, 4'd5, W'(16'h1234), W'(16'h5678));
      run_until_hs(10);
      check("ill_err", 64'(obs_err), 64'(ERR_EN));
      check("ill_data", obs_data, '0);
      check("ill_zero", 64'(obs_zero), 64'(1));

      // Randomized traffic with random backpressure and occasional withdrawn requests.
      for (int i = 0; i < 1500; i++) begin
         if (!req0_valid) begin
            if ($urandom_range(0, 2) == 0) drive(0, rand_op(), rand_opnd(), rand_opnd());
         end else if ($urandom_range(0, 19) == 0) begin
            req0_valid = 1'b0;
         end
         if (!req1_valid) begin
            if ($urandom_range(0, 2) == 0) drive(1, rand_op(), rand_opnd(), rand_opnd());
         end else if ($urandom_range(0, 19) == 0) begin
            req1_valid = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
